// File: rtl/ha1588_wb_master_if.sv
// Bundle for ha1588_wb_master: the host command/response stream and the Wishbone initiator side.
// The master modport is the bridge's own view; slave is the view of the host and bus slave.
interface ha1588_wb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        stb_o;
  logic        cyc_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, stb_o, cyc_o, we_o, adr_o, dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, stb_o, cyc_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/ha1588_wb_master.sv
// Command-FIFO-fed Wishbone initiator for the PTP core register bank; one response per command.
// Define WB_TIMEOUT_EN to abort bus cycles that wait TIMEOUT_CYC cycles without ack_i.
module ha1588_wb_master #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ha1588_wb_master_if.master bus,
  output logic               busy_o
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 in 2..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;
  state_e state_q, state_d;

  // Command FIFO
  logic [FIFO_DEPTH-1:0] mem_we;
  logic [31:0]           mem_adr [FIFO_DEPTH];
  logic [31:0]           mem_dat [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  push, pop, empty;
  logic                  head_we;
  logic [31:0]           head_adr, head_dat;

  assign empty         = (count_q == '0);
  assign bus.cmd_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == StIdle) && !empty;
  assign head_we       = mem_we[rd_ptr_q];
  assign head_adr      = mem_adr[rd_ptr_q];
  assign head_dat      = mem_dat[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_we[wr_ptr_q]  <= bus.cmd_we;
      mem_adr[wr_ptr_q] <= bus.cmd_adr;
      mem_dat[wr_ptr_q] <= bus.cmd_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Bus request and response registers
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Zero outside REQ, so the count always starts fresh on entry.
  assign tmo_d = (state_q == StReq && !bus.ack_i) ? tmo_q + 16'd1 : 16'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_adr[1:0] != 2'b00) begin
            state_d     = StRsp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = '0;
          end else begin
            state_d = StReq;
            we_d    = head_we;
            adr_d   = head_adr;
            dat_d   = head_dat;
          end
        end
      end
      StReq: begin
        if (bus.ack_i) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : bus.dat_i;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYC)) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end
`endif
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign bus.stb_o     = (state_q == StReq);
  assign bus.cyc_o     = (state_q == StReq);
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign busy_o        = !empty || (state_q != StIdle);
endmodule

// File: tb/tb_ha1588_wb_master.sv
// Scoreboard bench for ha1588_wb_master: modelled Wishbone slave, expected responses queued at push.
`timescale 1ns/1ps
module tb_ha1588_wb_master;
  localparam int unsigned Depth  = 4;
  localparam int unsigned TmoCyc = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  ha1588_wb_master_if bus ();

  ha1588_wb_master #(
    .FIFO_DEPTH (Depth),
    .TIMEOUT_CYC(TmoCyc)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return (a == 32'h24) ? 32'hCAFE_F00D : {a[15:0], ~a[15:0]};
  endfunction

  logic [32:0] sb_q  [$];  // {err, dat}
  logic [64:0] bus_q [$];  // {we, adr, dat}

  // Wishbone slave model; also throws stray acks while no strobe is up
  int unsigned wait_cyc = 0;
  bit          stall    = 1'b0;
  int unsigned wcnt = 0, stb_run = 0, last_run = 0, stb_cycles = 0;
  bit          stb_prev = 1'b0;
  int          rise_q [$];
  initial begin
    bus.ack_i = 1'b0;
    bus.dat_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack_i = 1'b0;
      bus.dat_i = $urandom;
      if (rst) begin
        wcnt = 0; stb_run = 0; stb_prev = 1'b0;
      end else if (bus.stb_o) begin
        if (!stb_prev) rise_q.push_back(cyc);
        stb_run++;
        stb_cycles++;
        stb_prev = 1'b1;
        if (!stall && wcnt >= wait_cyc) begin
          bus.ack_i = 1'b1;
          if (!bus.we_o) bus.dat_i = slave_rd(bus.adr_o);
          if (bus_q.size() == 0) check_eq("bus_spurious_stb", bus.stb_o, 1'b0);
          else check_eq("bus_req", {bus.we_o, bus.adr_o, bus.dat_o}, bus_q.pop_front());
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        if (stb_prev) last_run = stb_run;
        stb_run = 0; stb_prev = 1'b0; wcnt = 0;
        bus.ack_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor with optional random backpressure
  bit rsp_rand = 1'b0;
  int n_rsp    = 0;
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) check_eq("rsp_spurious_valid", bus.rsp_valid, 1'b0);
        else check_eq("rsp", {bus.rsp_err, bus.rsp_dat}, sb_q.pop_front());
        n_rsp++;
      end
    end
  end

  // mode 0: normal expectation, 1: expect timeout error, 2: no response expected
  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input int mode);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      check_eq("push_accept", bus.cmd_ready, 1'b1);
    end else if (mode == 0) begin
      if (adr[1:0] != 2'b00) begin
        sb_q.push_back({1'b1, 32'h0});
      end else begin
        sb_q.push_back({1'b0, we ? 32'h0 : slave_rd(adr)});
        bus_q.push_back({we, adr, dat});
      end
    end else if (mode == 1) begin
      sb_q.push_back({1'b1, 32'h0});
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_pending"}, sb_q.size(), 0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    check_eq("rst_stb_cyc", {bus.stb_o, bus.cyc_o}, 2'b00);
    check_eq("rst_busy_valid", {busy, bus.rsp_valid}, 2'b00);
    sb_q.delete();
    bus_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    step(3);
    check_eq("rst_flags", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.stb_o, bus.cyc_o,
                           bus.we_o, busy}, 7'b1000000);
    check_eq("rst_data", {bus.adr_o, bus.dat_o, bus.rsp_dat}, 96'h0);
    rst = 1'b0;
    step(1);

    // Write with one wait state; check issue latency
    wait_cyc = 1;
    push(1'b1, 32'h10, 32'h1234_5678, 0);
    check_eq("lat_n1_stb", {bus.stb_o, busy}, 2'b01);
    step(1);
    check_eq("lat_n2_stb", {bus.stb_o, bus.cyc_o, bus.we_o}, 3'b111);
    drain("write");
    check_eq("write_stb_len", last_run, 2);

    // Read with three wait states
    wait_cyc = 3;
    push(1'b0, 32'h24, 32'h0, 0);
    drain("read");
    check_eq("read_stb_len", last_run, 4);

    // FIFO fill while the slave stalls
    wait_cyc = 0;
    stall    = 1'b1;
    rsp_rand = 1'b1;
    for (int i = 0; i < 5; i++) push(i[0], 32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 0);
    check_eq("full_ready", {bus.cmd_ready, busy}, 2'b01);
    bus.cmd_valid = 1'b1;
    step(4);
    check_eq("full_hold", bus.cmd_ready, 1'b0);
    stall = 1'b0;
    push(1'b0, 32'h118, 32'h0, 0);
    drain("fifo");
    rsp_rand = 1'b0;

    // Back-to-back throughput
    rise_q.delete();
    for (int i = 0; i < 3; i++) push(1'b0, 32'h300 + 32'(i) * 4, 32'h0, 0);
    drain("thru");
    check_eq("thru_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check_eq("thru_gap1", rise_q[1] - rise_q[0], 3);
      check_eq("thru_gap2", rise_q[2] - rise_q[1], 3);
    end

    // Misaligned address: no bus cycle, error response
    s = int'(stb_cycles);
    push(1'b0, 32'h6, 32'h0, 0);
    drain("misalign");
    check_eq("misalign_no_stb", stb_cycles, s);
    push(1'b1, 32'h40, 32'h5555_AAAA, 0);
    push(1'b0, 32'h44, 32'h0, 0);
    drain("after_misalign");

    // Slave never acks
    stall = 1'b1;
`ifdef WB_TIMEOUT_EN
    push(1'b0, 32'h80, 32'h0, 1);
    drain("timeout");
    check_eq("timeout_stb_len", last_run, TmoCyc + 1);
`else
    push(1'b0, 32'h80, 32'h0, 2);
    step(40);
    check_eq("no_timeout_hold", {bus.stb_o, bus.rsp_valid}, 2'b10);
    do_reset();
`endif
    stall = 1'b0;

    // Reset mid-transaction with two commands queued
    stall = 1'b1;
    push(1'b0, 32'h200, 32'h0, 0);
    push(1'b1, 32'h204, 32'h1111_2222, 0);
    push(1'b0, 32'h208, 32'h0, 0);
    step(2);
    check_eq("pre_rst_stb", bus.stb_o, 1'b1);
    s = n_rsp;
    do_reset();
    stall = 1'b0;
    step(20);
    check_eq("post_rst_no_rsp", n_rsp, s);
    push(1'b0, 32'h20C, 32'h0, 0);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
